// File: rtl/traffic_monitor.sv
// Watches NS/WE lamp vectors from a traffic controller and latches the first rule violation.
// Define TRAFFIC_MON_STATS_EN to add the cycles_done completed-cycle counter output.
module traffic_monitor #(
   parameter int unsigned GREEN_CYC  = 15,
   parameter int unsigned YELLOW_CYC = 3,
   parameter int unsigned ALLRED_CYC = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  led_ns,
   input  logic [2:0]  led_we,
   input  logic        clr_fault,
   output logic [2:0]  phase,
   output logic        phase_valid,
   output logic        fault,
   output logic [2:0]  fault_code,
   output logic        force_red
`ifdef TRAFFIC_MON_STATS_EN
   ,
   output logic [15:0] cycles_done
`endif
);

   typedef enum logic [1:0] {
      ST_ACQ_WAIT = 2'd0,
      ST_ACQ_PART = 2'd1,
      ST_RUN      = 2'd2,
      ST_FAULT    = 2'd3
   } state_t;

   localparam logic [2:0] CODE_NONE     = 3'd0;
   localparam logic [2:0] CODE_ENC      = 3'd1;
   localparam logic [2:0] CODE_CONFLICT = 3'd2;
   localparam logic [2:0] CODE_SEQ      = 3'd3;
   localparam logic [2:0] CODE_SHORT    = 3'd4;
   localparam logic [2:0] CODE_LONG     = 3'd5;

   localparam logic [7:0] REQ_GREEN  = 8'(GREEN_CYC);
   localparam logic [7:0] REQ_YELLOW = 8'(YELLOW_CYC);
   localparam logic [7:0] REQ_ALLRED = 8'(ALLRED_CYC);

   function automatic logic f_onehot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   function automatic logic [2:0] f_inc6(input logic [2:0] p);
      return (p == 3'd5) ? 3'd0 : p + 3'd1;
   endfunction

   function automatic logic [7:0] f_req(input logic [2:0] p);
      case (p)
         3'd0, 3'd3: return REQ_GREEN;
         3'd1, 3'd4: return REQ_YELLOW;
         default:    return REQ_ALLRED;
      endcase
   endfunction

   state_t      r_state;
   logic [2:0]  r_phase;
   logic        r_valid;
   logic        r_fault;
   logic [2:0]  r_code;
   logic        r_force;
   logic [7:0]  r_dwell;

   state_t      w_state_nxt;
   logic [2:0]  w_phase_nxt;
   logic        w_valid_nxt;
   logic        w_fault_nxt;
   logic [2:0]  w_code_nxt;
   logic        w_force_nxt;
   logic [7:0]  w_dwell_nxt;

   logic        w_enc;
   logic        w_conflict;
   logic        w_rr;
   logic [2:0]  w_smp_phase;
   logic        w_smp_known;
   logic        w_change;
   logic        w_acq_ok;
   logic [2:0]  w_code;

   assign w_enc      = !(f_onehot3(led_ns) && f_onehot3(led_we));
   assign w_conflict = !led_ns[2] && !led_we[2];
   assign w_rr       = (led_ns == 3'b100) && (led_we == 3'b100);
   assign w_change   = (w_smp_phase != r_phase);
   // ACQ_WAIT never resolves R/R: the previous phase is not trusted there.
   assign w_acq_ok   = w_smp_known && !w_rr;

   // Decode the current lamp sample into a phase number.
   always_comb begin
      w_smp_phase = 3'd0;
      w_smp_known = 1'b0;
      case ({led_ns, led_we})
         6'b001_100: begin w_smp_phase = 3'd0; w_smp_known = 1'b1; end
         6'b010_100: begin w_smp_phase = 3'd1; w_smp_known = 1'b1; end
         6'b100_001: begin w_smp_phase = 3'd3; w_smp_known = 1'b1; end
         6'b100_010: begin w_smp_phase = 3'd4; w_smp_known = 1'b1; end
         6'b100_100: begin
            if ((r_phase == 3'd1) || (r_phase == 3'd2)) begin
               w_smp_phase = 3'd2;
               w_smp_known = 1'b1;
            end else if ((r_phase == 3'd4) || (r_phase == 3'd5)) begin
               w_smp_phase = 3'd5;
               w_smp_known = 1'b1;
            end else begin
               w_smp_known = 1'b0;
            end
         end
         default: w_smp_known = 1'b0;
      endcase
   end

   // Prioritised violation code for the current sample.
   always_comb begin
      w_code = CODE_NONE;
      if (w_conflict) begin
         w_code = CODE_CONFLICT;
      end else if (w_enc) begin
         w_code = CODE_ENC;
      end else begin
         case (r_state)
            ST_ACQ_PART: begin
               if (!w_smp_known || (w_change && (w_smp_phase != f_inc6(r_phase))))
                  w_code = CODE_SEQ;
               else
                  w_code = CODE_NONE;
            end
            ST_RUN: begin
               if (!w_smp_known || (w_change && (w_smp_phase != f_inc6(r_phase))))
                  w_code = CODE_SEQ;
               else if (w_change && (r_dwell < f_req(r_phase)))
                  w_code = CODE_SHORT;
               else if (!w_change && (r_dwell >= f_req(r_phase)))
                  w_code = CODE_LONG;
               else
                  w_code = CODE_NONE;
            end
            default: w_code = CODE_NONE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_ACQ_WAIT;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACQ_WAIT: begin
            if (w_code != CODE_NONE) w_state_nxt = ST_FAULT;
            else if (w_acq_ok)       w_state_nxt = ST_ACQ_PART;
            else                     w_state_nxt = ST_ACQ_WAIT;
         end
         ST_ACQ_PART: begin
            if (w_code != CODE_NONE) w_state_nxt = ST_FAULT;
            else if (w_change)       w_state_nxt = ST_RUN;
            else                     w_state_nxt = ST_ACQ_PART;
         end
         ST_RUN: begin
            if (w_code != CODE_NONE) w_state_nxt = ST_FAULT;
            else                     w_state_nxt = ST_RUN;
         end
         ST_FAULT: begin
            if (clr_fault && (w_code == CODE_NONE)) w_state_nxt = ST_ACQ_WAIT;
            else                                    w_state_nxt = ST_FAULT;
         end
         default: w_state_nxt = ST_ACQ_WAIT;
      endcase
   end

   // Next values of the registered outputs and the dwell counter.
   always_comb begin
      w_phase_nxt = r_phase;
      w_valid_nxt = r_valid;
      w_fault_nxt = r_fault;
      w_code_nxt  = r_code;
      w_force_nxt = r_force;
      w_dwell_nxt = r_dwell;
      if (r_state == ST_FAULT) begin
         if (clr_fault && (w_code == CODE_NONE)) begin
            w_fault_nxt = 1'b0;
            w_code_nxt  = CODE_NONE;
            w_force_nxt = 1'b0;
            w_valid_nxt = 1'b0;
            w_dwell_nxt = 8'd0;
         end else if (clr_fault) begin
            w_code_nxt  = w_code;
         end else begin
            w_code_nxt  = r_code;
         end
      end else if (w_code != CODE_NONE) begin
         w_fault_nxt = 1'b1;
         w_force_nxt = 1'b1;
         w_code_nxt  = w_code;
      end else begin
         case (r_state)
            ST_ACQ_WAIT: begin
               if (w_acq_ok) begin
                  w_phase_nxt = w_smp_phase;
                  w_valid_nxt = 1'b1;
                  w_dwell_nxt = 8'd0;
               end else begin
                  w_phase_nxt = r_phase;
               end
            end
            ST_ACQ_PART: begin
               w_phase_nxt = w_smp_phase;
               w_dwell_nxt = w_change ? 8'd1 : 8'd0;
            end
            ST_RUN: begin
               w_phase_nxt = w_smp_phase;
               if (w_change)               w_dwell_nxt = 8'd1;
               else if (r_dwell == 8'd255) w_dwell_nxt = 8'd255;
               else                        w_dwell_nxt = r_dwell + 8'd1;
            end
            default: w_phase_nxt = r_phase;
         endcase
      end
   end

   // Output and dwell registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= 3'd0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         r_code  <= CODE_NONE;
         r_force <= 1'b0;
         r_dwell <= 8'd0;
      end else begin
         r_phase <= w_phase_nxt;
         r_valid <= w_valid_nxt;
         r_fault <= w_fault_nxt;
         r_code  <= w_code_nxt;
         r_force <= w_force_nxt;
         r_dwell <= w_dwell_nxt;
      end
   end

   assign phase       = r_phase;
   assign phase_valid = r_valid;
   assign fault       = r_fault;
   assign fault_code  = r_code;
   assign force_red   = r_force;

`ifdef TRAFFIC_MON_STATS_EN
   logic [15:0] r_cycles;
   logic        w_cyc_inc;

   assign w_cyc_inc = (r_state == ST_RUN) && (w_code == CODE_NONE) &&
                      (r_phase == 3'd5) && (w_smp_phase == 3'd0);

   // Completed-cycle counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_cycles <= 16'd0;
      else if (w_cyc_inc) r_cycles <= r_cycles + 16'd1;
      else                r_cycles <= r_cycles;
   end

   assign cycles_done = r_cycles;
`endif

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed, table-driven bench for traffic_monitor; honours TRAFFIC_MON_STATS_EN.
module tb_traffic_monitor;

   localparam logic [2:0] LG = 3'b001;
   localparam logic [2:0] LY = 3'b010;
   localparam logic [2:0] LR = 3'b100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  led_ns;
   logic [2:0]  led_we;
   logic        clr_fault;
   logic [2:0]  phase;
   logic        phase_valid;
   logic        fault;
   logic [2:0]  fault_code;
   logic        force_red;
`ifdef TRAFFIC_MON_STATS_EN
   logic [15:0] cycles_done;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0] ns;
      logic [2:0] we;
      logic       clr;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[14];
   logic [8:0] obs;
   assign obs = {phase, phase_valid, fault, fault_code, force_red};

   always #5 clk = ~clk;

   traffic_monitor #(.GREEN_CYC(15), .YELLOW_CYC(3), .ALLRED_CYC(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .led_ns     (led_ns),
      .led_we     (led_we),
      .clr_fault  (clr_fault),
      .phase      (phase),
      .phase_valid(phase_valid),
      .fault      (fault),
      .fault_code (fault_code),
      .force_red  (force_red)
`ifdef TRAFFIC_MON_STATS_EN
      ,
      .cycles_done(cycles_done)
`endif
   );

   function automatic logic [8:0] pk(input logic [2:0] ph, input logic v, input logic f,
                                     input logic [2:0] c, input logic r);
      return {ph, v, f, c, r};
   endfunction

   function automatic vec_t mk(input logic [2:0] ns, input logic [2:0] we, input logic clr,
                               input logic [8:0] exp);
      vec_t t;
      t.ns = ns; t.we = we; t.clr = clr; t.exp = exp;
      return t;
   endfunction

   function automatic logic [5:0] lamps_of(input int p);
      case (p)
         0:       return {LG, LR};
         1:       return {LY, LR};
         3:       return {LR, LG};
         4:       return {LR, LY};
         default: return {LR, LR};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] ns, input logic [2:0] we, input logic clr);
      @(negedge clk);
      led_ns = ns; led_we = we; clr_fault = clr;
      @(posedge clk);
      #1;
   endtask

   // From ACQ_WAIT: acquire at phase 3, then run 4,5 into phase 0 with dwell 1.
   task automatic to_run_ph0();
      drive(LR, LG, 1'b0);
      for (int i = 0; i < 3; i++) drive(LR, LY, 1'b0);
      for (int i = 0; i < 3; i++) drive(LR, LR, 1'b0);
      drive(LG, LR, 1'b0);
      check("to_run_ph0", obs, pk(3'd0, 1'b1, 1'b0, 3'd0, 1'b0));
   endtask

   initial begin
      int dw[6];
      logic [5:0] lm;
      dw = '{15, 3, 3, 15, 3, 3};

      tbl[0]  = mk(LG, LR, 1'b0, pk(3'd0, 1'b1, 1'b0, 3'd0, 1'b0));
      tbl[1]  = mk(LG, LG, 1'b0, pk(3'd0, 1'b1, 1'b1, 3'd2, 1'b1));
      tbl[2]  = mk(3'b011, LR, 1'b0, pk(3'd0, 1'b1, 1'b1, 3'd2, 1'b1));
      tbl[3]  = mk(LR, LR, 1'b1, pk(3'd0, 1'b0, 1'b0, 3'd0, 1'b0));
      tbl[4]  = mk(LR, LR, 1'b0, pk(3'd0, 1'b0, 1'b0, 3'd0, 1'b0));
      tbl[5]  = mk(LR, LG, 1'b0, pk(3'd3, 1'b1, 1'b0, 3'd0, 1'b0));
      tbl[6]  = mk(LR, LG, 1'b1, pk(3'd3, 1'b1, 1'b0, 3'd0, 1'b0));
      tbl[7]  = mk(LR, LY, 1'b0, pk(3'd4, 1'b1, 1'b0, 3'd0, 1'b0));
      tbl[8]  = mk(LR, LY, 1'b0, pk(3'd4, 1'b1, 1'b0, 3'd0, 1'b0));
      tbl[9]  = mk(LR, LR, 1'b0, pk(3'd4, 1'b1, 1'b1, 3'd4, 1'b1));
      tbl[10] = mk(3'b011, 3'b011, 1'b1, pk(3'd4, 1'b1, 1'b1, 3'd2, 1'b1));
      tbl[11] = mk(LG, LR, 1'b1, pk(3'd4, 1'b0, 1'b0, 3'd0, 1'b0));
      tbl[12] = mk(3'b110, LR, 1'b0, pk(3'd4, 1'b0, 1'b1, 3'd1, 1'b1));
      tbl[13] = mk(LG, LR, 1'b1, pk(3'd4, 1'b0, 1'b0, 3'd0, 1'b0));

      rst_n = 1'b0; led_ns = LR; led_we = LR; clr_fault = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", obs, pk(3'd0, 1'b0, 1'b0, 3'd0, 1'b0));
`ifdef TRAFFIC_MON_STATS_EN
      check("reset_cycles", cycles_done, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Three full legal cycles from reset.
      for (int c = 0; c < 3; c++) begin
         for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < dw[p]; k++) begin
               lm = lamps_of(p);
               drive(lm[5:3], lm[2:0], 1'b0);
               check("legal_run", obs, pk(3'(p), 1'b1, 1'b0, 3'd0, 1'b0));
            end
         end
      end
`ifdef TRAFFIC_MON_STATS_EN
      check("cycles_after_3", cycles_done, 32'd2);
`endif

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].ns, tbl[i].we, tbl[i].clr);
         check($sformatf("tbl[%0d]", i), obs, tbl[i].exp);
      end
`ifdef TRAFFIC_MON_STATS_EN
      check("cycles_hold", cycles_done, 32'd3);
`endif

      // SHORT: phase 1 held two samples then R/R.
      drive(LG, LR, 1'b0);
      drive(LY, LR, 1'b0);
      drive(LY, LR, 1'b0);
      check("short_pre", obs, pk(3'd1, 1'b1, 1'b0, 3'd0, 1'b0));
      drive(LR, LR, 1'b0);
      check("short", obs, pk(3'd1, 1'b1, 1'b1, 3'd4, 1'b1));
      drive(LG, LR, 1'b1);

      // LONG: 16th sample of phase 0 in RUN.
      to_run_ph0();
      for (int i = 0; i < 14; i++) drive(LG, LR, 1'b0);
      check("long_15th", obs, pk(3'd0, 1'b1, 1'b0, 3'd0, 1'b0));
      drive(LG, LR, 1'b0);
      check("long_16th", obs, pk(3'd0, 1'b1, 1'b1, 3'd5, 1'b1));
      drive(LG, LR, 1'b1);

      // SEQ, clear refused on a bad sample, then clear accepted.
      to_run_ph0();
      drive(LR, LG, 1'b0);
      check("seq", obs, pk(3'd0, 1'b1, 1'b1, 3'd3, 1'b1));
      drive(3'b011, LR, 1'b1);
      check("clr_with_enc", obs, pk(3'd0, 1'b1, 1'b1, 3'd1, 1'b1));
      drive(LG, LR, 1'b1);
      check("clr_ok", obs, pk(3'd0, 1'b0, 1'b0, 3'd0, 1'b0));
      drive(LG, LR, 1'b0);
      check("reacquire", obs, pk(3'd0, 1'b1, 1'b0, 3'd0, 1'b0));

      // Asynchronous reset during phase 3, restart in R/R.
      for (int i = 0; i < 3; i++) drive(LY, LR, 1'b0);
      for (int i = 0; i < 3; i++) drive(LR, LR, 1'b0);
      drive(LR, LG, 1'b0);
      drive(LR, LG, 1'b0);
      check("pre_reset_ph3", obs, pk(3'd3, 1'b1, 1'b0, 3'd0, 1'b0));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", obs, pk(3'd0, 1'b0, 1'b0, 3'd0, 1'b0));
      led_ns = LR; led_we = LR;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(LR, LR, 1'b0);
         check("restart_rr", obs, pk(3'd0, 1'b0, 1'b0, 3'd0, 1'b0));
      end
      drive(LR, LG, 1'b0);
      check("restart_acq", obs, pk(3'd3, 1'b1, 1'b0, 3'd0, 1'b0));
`ifdef TRAFFIC_MON_STATS_EN
      check("cycles_after_reset", cycles_done, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
